// File: rtl/inst_axi_rd_bridge_pkg.sv
// Shared types and fixed AXI3 encodings for the instruction read bridge.
package inst_axi_rd_bridge_pkg;

    typedef enum logic {
        AR_IDLE = 1'b0,
        AR_BUSY = 1'b1
    } ar_state_e;

    localparam logic [7:0] AXI_LEN_1      = 8'h00;
    localparam logic [1:0] AXI_BURST_INCR = 2'b01;
    localparam logic [1:0] AXI_LOCK_NORM  = 2'b00;
    localparam logic [3:0] AXI_CACHE_NONE = 4'h0;
    localparam logic [2:0] AXI_PROT_NONE  = 3'h0;

    // Simultaneous accept and return leave the count unchanged.
    function automatic logic [1:0] cnt_update(
        input logic [1:0] cnt,
        input logic       inc,
        input logic       dec
    );
        logic [1:0] nxt;
        nxt = cnt;
        unique case ({inc, dec})
            2'b10:   nxt = cnt + 2'd1;
            2'b01:   nxt = cnt - 2'd1;
            default: nxt = cnt;
        endcase
        return nxt;
    endfunction

endpackage

// File: rtl/inst_axi_rd_bridge.sv
// IF-stage SRAM-like instruction port to single-beat AXI3 read master.
// AR payload is latched on accept so IF may retarget while req is held.
module inst_axi_rd_bridge
    import inst_axi_rd_bridge_pkg::*;
#(
    parameter int unsigned OUTSTANDING = 2,
    parameter logic [3:0]  ARID_VAL    = 4'h0
) (
    input  logic        clk,
    input  logic        reset,
    input  logic        inst_sram_req,
    input  logic        inst_sram_wr,
    input  logic [1:0]  inst_sram_size,
    input  logic [31:0] inst_sram_addr,
    input  logic [3:0]  inst_sram_wstrb,
    input  logic [31:0] inst_sram_wdata,
    output logic        inst_sram_addr_ok,
    output logic        inst_sram_data_ok,
    output logic [31:0] inst_sram_rdata,
    output logic [3:0]  arid,
    output logic [31:0] araddr,
    output logic [7:0]  arlen,
    output logic [2:0]  arsize,
    output logic [1:0]  arburst,
    output logic [1:0]  arlock,
    output logic [3:0]  arcache,
    output logic [2:0]  arprot,
    output logic        arvalid,
    input  logic        arready,
    input  logic [3:0]  rid,
    input  logic [31:0] rdata,
    input  logic [1:0]  rresp,
    input  logic        rlast,
    input  logic        rvalid,
    output logic        rready
);

    localparam logic [1:0] MAX_CNT = 2'(OUTSTANDING);

    ar_state_e   state_q, state_d;
    logic [31:0] araddr_q, araddr_d;
    logic [2:0]  arsize_q, arsize_d;
    logic [1:0]  cnt_q, cnt_d;
    logic        data_ok_q, data_ok_d;
    logic [31:0] rdata_q, rdata_d;
    logic        accept;
    logic        r_hs;

    // Write channel, response and ID are intentionally unused.
    logic unused_inputs;
    assign unused_inputs = ^{inst_sram_wr, inst_sram_wstrb,
                             inst_sram_wdata, rid, rresp};

    always_comb begin
        state_d = state_q;
        accept  = 1'b0;
        arvalid = 1'b0;
        unique case (state_q)
            AR_IDLE: begin
                accept = inst_sram_req && (cnt_q < MAX_CNT) && !reset;
                if (accept) state_d = AR_BUSY;
            end
            AR_BUSY: begin
                arvalid = 1'b1;
                if (arready) state_d = AR_IDLE;
            end
            default: state_d = AR_IDLE;
        endcase
    end

    assign rready = (cnt_q != 2'd0);
    assign r_hs   = rvalid && rready && rlast;

    always_comb begin
        araddr_d  = araddr_q;
        arsize_d  = arsize_q;
        if (accept) begin
            araddr_d = inst_sram_addr;
            arsize_d = {1'b0, inst_sram_size};
        end
        cnt_d     = cnt_update(cnt_q, accept, r_hs);
        data_ok_d = r_hs;
        rdata_d   = r_hs ? rdata : rdata_q;
    end

    always_ff @(posedge clk) begin
        if (reset) begin
            state_q   <= AR_IDLE;
            araddr_q  <= 32'h0;
            arsize_q  <= 3'h0;
            cnt_q     <= 2'd0;
            data_ok_q <= 1'b0;
            rdata_q   <= 32'h0;
        end else begin
            state_q   <= state_d;
            araddr_q  <= araddr_d;
            arsize_q  <= arsize_d;
            cnt_q     <= cnt_d;
            data_ok_q <= data_ok_d;
            rdata_q   <= rdata_d;
        end
    end

    assign inst_sram_addr_ok = accept;
    assign inst_sram_data_ok = data_ok_q;
    assign inst_sram_rdata   = rdata_q;

    assign arid    = ARID_VAL;
    assign araddr  = araddr_q;
    assign arlen   = AXI_LEN_1;
    assign arsize  = arsize_q;
    assign arburst = AXI_BURST_INCR;
    assign arlock  = AXI_LOCK_NORM;
    assign arcache = AXI_CACHE_NONE;
    assign arprot  = AXI_PROT_NONE;

endmodule

// File: tb/tb_inst_axi_rd_bridge.sv
// Scripted scenarios for the instruction read bridge; returned data is
// checked against a queue filled when each R beat is driven.
module tb_inst_axi_rd_bridge;

    logic        clk = 1'b0;
    logic        reset;
    logic        req, wr;
    logic [1:0]  size;
    logic [31:0] addr;
    logic [3:0]  wstrb;
    logic [31:0] wdata;
    logic        addr_ok, data_ok;
    logic [31:0] irdata;
    logic [3:0]  arid;
    logic [31:0] araddr;
    logic [7:0]  arlen;
    logic [2:0]  arsize;
    logic [1:0]  arburst, arlock;
    logic [3:0]  arcache;
    logic [2:0]  arprot;
    logic        arvalid, arready;
    logic [3:0]  rid;
    logic [31:0] rdata;
    logic [1:0]  rresp;
    logic        rlast, rvalid, rready;

    int vectors = 0;
    int miscompares = 0;
    logic [31:0] exp_q[$];

    inst_axi_rd_bridge #(.OUTSTANDING(2), .ARID_VAL(4'h0)) dut (
        .clk(clk), .reset(reset),
        .inst_sram_req(req), .inst_sram_wr(wr),
        .inst_sram_size(size), .inst_sram_addr(addr),
        .inst_sram_wstrb(wstrb), .inst_sram_wdata(wdata),
        .inst_sram_addr_ok(addr_ok), .inst_sram_data_ok(data_ok),
        .inst_sram_rdata(irdata),
        .arid(arid), .araddr(araddr), .arlen(arlen), .arsize(arsize),
        .arburst(arburst), .arlock(arlock), .arcache(arcache),
        .arprot(arprot), .arvalid(arvalid), .arready(arready),
        .rid(rid), .rdata(rdata), .rresp(rresp), .rlast(rlast),
        .rvalid(rvalid), .rready(rready)
    );

    always #5 clk = ~clk;

    initial begin
        #200000;
        $display("FAIL watchdog: sim time limit reached");
        $fatal(1, "timeout");
    end

    // Continuous checks: in-order data, count bounds, AR stability.
    logic        p_arvalid = 1'b0, p_arready = 1'b0;
    logic [31:0] p_araddr = 32'h0;
    logic [2:0]  p_arsize = 3'h0;
    always @(negedge clk) begin
        if (!reset) begin
            vectors++;
            if (dut.cnt_q > 2'd2) begin
                miscompares++;
                $display("FAIL cnt_bound: cnt=%0d limit=2", dut.cnt_q);
            end
            if (data_ok) begin
                vectors++;
                if (exp_q.size() == 0) begin
                    miscompares++;
                    $display("FAIL rdata_order: got %h, expected none", irdata);
                end else begin
                    logic [31:0] e;
                    e = exp_q.pop_front();
                    if (irdata !== e) begin
                        miscompares++;
                        $display("FAIL rdata_order: got %h, expected %h",
                                 irdata, e);
                    end
                end
            end
            if (p_arvalid && !p_arready) begin
                vectors++;
                if (arvalid !== 1'b1 || araddr !== p_araddr ||
                    arsize !== p_arsize) begin
                    miscompares++;
                    $display("FAIL ar_stable: v=%b a=%h s=%0d, need v=1 a=%h s=%0d",
                             arvalid, araddr, arsize, p_araddr, p_arsize);
                end
            end
        end
        p_arvalid = reset ? 1'b0 : arvalid;
        p_arready = arready;
        p_araddr  = araddr;
        p_arsize  = arsize;
    end

    task automatic tick;
        @(posedge clk);
        #1;
    endtask

    task automatic chk1(input string nm, input logic got, input logic exp);
        vectors++;
        if (got !== exp) begin
            miscompares++;
            $display("FAIL %s: got %b, expected %b", nm, got, exp);
        end
    endtask

    task automatic chk32(input string nm, input logic [31:0] got,
                         input logic [31:0] exp);
        vectors++;
        if (got !== exp) begin
            miscompares++;
            $display("FAIL %s: got %h, expected %h", nm, got, exp);
        end
    endtask

    // Accept one request and complete its AR beat with a 1-cycle arready.
    task automatic issue(input logic [31:0] a);
        req = 1'b1; addr = a; size = 2'd2;
        #1;
        chk1("issue_addr_ok", addr_ok, 1'b1);
        tick();
        req = 1'b0; arready = 1'b1;
        tick();
        arready = 1'b0;
    endtask

    // One R beat, with an error response and random ID to show both ignored.
    task automatic r_beat(input logic [31:0] d);
        rvalid = 1'b1; rlast = 1'b1; rdata = d;
        rresp = 2'b10; rid = 4'($urandom_range(0, 15));
        exp_q.push_back(d);
        tick();
        rvalid = 1'b0; rlast = 1'b0;
    endtask

    task automatic test_reset;
        reset = 1'b1; req = 1'b1; wr = 1'b0; size = 2'd2;
        addr = 32'hbfc00000; wstrb = 4'h0; wdata = 32'h0;
        arready = 1'b0; rid = 4'h0; rdata = 32'h0; rresp = 2'b00;
        rlast = 1'b0; rvalid = 1'b0;
        tick(); tick();
        chk1("rst_addr_ok", addr_ok, 1'b0);
        chk1("rst_arvalid", arvalid, 1'b0);
        chk32("rst_araddr", araddr, 32'h0);
        chk32("rst_arsize", 32'(arsize), 32'h0);
        chk1("rst_data_ok", data_ok, 1'b0);
        chk32("rst_rdata", irdata, 32'h0);
        chk1("rst_rready", rready, 1'b0);
        reset = 1'b0; req = 1'b0;
        tick();
    endtask

    task automatic test_single_fetch;
        req = 1'b1; addr = 32'hbfc00000; size = 2'd2;
        #1;
        chk1("sf_addr_ok_t", addr_ok, 1'b1);
        tick();
        req = 1'b0; arready = 1'b1;
        #1;
        chk1("sf_arvalid_t1", arvalid, 1'b1);
        chk32("sf_araddr", araddr, 32'hbfc00000);
        chk32("sf_arsize", 32'(arsize), 32'd2);
        chk32("sf_ar_const", {arid, arlen, arburst, arlock, arcache, arprot},
              {4'h0, 8'h00, 2'b01, 2'b00, 4'h0, 3'h0});
        chk1("sf_rready_t1", rready, 1'b1);
        tick();
        arready = 1'b0;
        #1;
        chk1("sf_arvalid_t2", arvalid, 1'b0);
        tick();
        r_beat(32'h3c080001);
        #1;
        chk1("sf_data_ok_t4", data_ok, 1'b1);
        chk32("sf_rdata_t4", irdata, 32'h3c080001);
        tick();
        chk1("sf_data_ok_t5", data_ok, 1'b0);
        chk32("sf_rdata_hold", irdata, 32'h3c080001);
        chk32("sf_cnt", 32'(dut.cnt_q), 32'd0);
    endtask

    task automatic test_addr_change;
        req = 1'b1; addr = 32'hbfc00004; size = 2'd2;
        #1;
        chk1("ac_addr_ok", addr_ok, 1'b1);
        tick();
        addr = 32'hbfc00380;
        for (int i = 0; i < 5; i++) begin
            #1;
            chk1("ac_addr_ok_stall", addr_ok, 1'b0);
            chk32("ac_araddr_stall", araddr, 32'hbfc00004);
            tick();
        end
        arready = 1'b1;
        #1;
        chk32("ac_araddr_hs", araddr, 32'hbfc00004);
        chk1("ac_addr_ok_hs", addr_ok, 1'b0);
        req = 1'b0;
        tick();
        arready = 1'b0;
        r_beat(32'hdeadbeef);
        tick();
        chk32("ac_cnt", 32'(dut.cnt_q), 32'd0);
    endtask

    task automatic test_limit;
        int pulses;
        pulses = 0;
        arready = 1'b1; req = 1'b1; addr = 32'hbfc00100;
        for (int i = 0; i < 8; i++) begin
            #1;
            if (addr_ok) pulses++;
            tick();
        end
        chk32("lim_pulses", 32'(pulses), 32'd2);
        chk32("lim_cnt", 32'(dut.cnt_q), 32'd2);
        rvalid = 1'b1; rlast = 1'b1; rdata = 32'haaaa0001;
        exp_q.push_back(32'haaaa0001);
        #1;
        chk1("lim_addr_ok_hs", addr_ok, 1'b0);
        tick();
        rvalid = 1'b0; rlast = 1'b0;
        #1;
        chk1("lim_addr_ok_after", addr_ok, 1'b1);
        tick();
        req = 1'b0;
        tick();
        arready = 1'b0;
        r_beat(32'haaaa0002);
        r_beat(32'haaaa0003);
        tick();
        chk32("lim_cnt_end", 32'(dut.cnt_q), 32'd0);
    endtask

    task automatic test_in_order;
        issue(32'hbfc00010);
        issue(32'hbfc00014);
        exp_q.push_back(32'h11111111);
        rvalid = 1'b1; rlast = 1'b1; rdata = 32'h11111111;
        tick();
        exp_q.push_back(32'h22222222);
        rdata = 32'h22222222;
        #1;
        chk1("io_data_ok_1", data_ok, 1'b1);
        chk32("io_rdata_1", irdata, 32'h11111111);
        tick();
        rvalid = 1'b0; rlast = 1'b0;
        #1;
        chk1("io_data_ok_2", data_ok, 1'b1);
        chk32("io_rdata_2", irdata, 32'h22222222);
        tick();
        chk1("io_data_ok_3", data_ok, 1'b0);
        chk32("io_cnt", 32'(dut.cnt_q), 32'd0);
    endtask

    task automatic test_simultaneous;
        issue(32'hbfc00020);
        chk32("sim_cnt_pre", 32'(dut.cnt_q), 32'd1);
        req = 1'b1; addr = 32'hbfc00024;
        rvalid = 1'b1; rlast = 1'b1; rdata = 32'h55aa55aa;
        exp_q.push_back(32'h55aa55aa);
        #1;
        chk1("sim_addr_ok", addr_ok, 1'b1);
        chk1("sim_rready", rready, 1'b1);
        tick();
        req = 1'b0; rvalid = 1'b0; rlast = 1'b0;
        chk32("sim_cnt", 32'(dut.cnt_q), 32'd1);
        arready = 1'b1;
        tick();
        arready = 1'b0;
        r_beat(32'h0badf00d);
        tick();
        chk32("sim_cnt_end", 32'(dut.cnt_q), 32'd0);
    endtask

    task automatic test_reset_mid;
        issue(32'hbfc00030);
        req = 1'b1; addr = 32'hbfc00034;
        #1;
        chk1("rm_addr_ok", addr_ok, 1'b1);
        tick();
        req = 1'b0;
        chk1("rm_busy_arvalid", arvalid, 1'b1);
        chk32("rm_cnt_pre", 32'(dut.cnt_q), 32'd2);
        reset = 1'b1;
        tick();
        reset = 1'b0;
        chk1("rm_arvalid", arvalid, 1'b0);
        chk1("rm_rready", rready, 1'b0);
        chk1("rm_data_ok", data_ok, 1'b0);
        chk32("rm_cnt", 32'(dut.cnt_q), 32'd0);
        issue(32'hbfc00040);
        r_beat(32'h12345678);
        tick();
        chk32("rm_cnt_end", 32'(dut.cnt_q), 32'd0);
    endtask

    initial begin
        test_reset();
        test_single_fetch();
        test_addr_change();
        test_limit();
        test_in_order();
        test_simultaneous();
        test_reset_mid();
        tick();
        vectors++;
        if (exp_q.size() != 0) begin
            miscompares++;
            $display("FAIL queue_drain: %0d returns missing, expected 0",
                     exp_q.size());
        end
        $display("== %0d vectors applied, %0d miscompares ==",
                 vectors, miscompares);
        $finish;
    end

endmodule
